regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Port A: the in-order pipeline writeback. Unbuffered, high priority.
  - Port B: multiply/divide completions. Buffered in a small FIFO.
- Drives registered write enable, address, data and a 32-bit one-hot write-select vector.
- Adds starvation protection for B and write-after-write squashing of stale B results.

Parameters:
- DEPTH, 2, number of B FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, cycles a valid B head may wait before it forcibly wins arbitration.
- DATA_W, 32, writeback data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- a_valid  in  1  pipeline writeback request.
- a_addr  in  5  destination register.
- a_data  in  DATA_W  write data.
- a_ready  out  1  A accepted when a_valid && a_ready.
- b_valid  in  1  multdiv result request.
- b_addr  in  5  destination register.
- b_data  in  DATA_W  result data.
- b_ready  out  1  FIFO can accept.
- wr_en  out  1  register file write strobe (registered).
- wr_addr  out  5  write address (registered).
- wr_data  out  DATA_W  write data (registered).
- wr_onehot  out  32  decoded write select, all-zero when !wr_en; bit 0 never set.
- wr_src  out  1  0 = A, 1 = B (registered).
- b_pending  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: applied on the clock edge while reset==0.
  - wr_en=0, wr_addr=0, wr_data=0, wr_onehot=0, wr_src=0.
  - FIFO emptied, b_pending=0, starve counter=0.
  - Reset mid-operation discards all buffered B entries.
- Latency: a grant in cycle t appears on the wr_* outputs in cycle t+1. One write per cycle maximum.
- a_ready (combinational) = !force_b, where force_b = (starve_cnt == STARVE_LIMIT) && head valid.
- b_ready = (count < DEPTH), registered-state based. There is no enqueue-to-output bypass: an entry enqueued at t is first eligible at t+1.
- Enqueue with addr 0: accepted (b_ready honoured) but not stored.
- Arbitration per cycle, in priority order:
  1. FIFO head marked invalid: pop it without a write. This consumes no port slot, and A may still be granted this cycle.
  2. force_b: grant head, pop, a_ready=0.
  3. A accepted: grant A.
  4. Head valid and no A request: grant head, pop.
  5. Otherwise wr_en=0 next cycle.
- A grant with a_addr==0: accepted, but wr_en=0 next cycle. It still counts as A activity for starvation.
- Starve counter:
  - Increments each cycle a valid head exists and is not granted, saturating at STARVE_LIMIT.
  - Clears on a B grant or when the FIFO is empty or its head is invalid.
- WAW squash: when A is accepted with addr r≠0, every valid FIFO entry with addr r is marked invalid in the same cycle.
  - Includes an entry being enqueued that same cycle with addr r.
  - Newer pipeline write wins.
- Simultaneous enqueue and dequeue when full: b_ready is 0 (based on registered count), so no enqueue occurs. Enqueue and dequeue in the same cycle when not full: count unchanged.
- FIFO pointers wrap modulo DEPTH. Count is DEPTH+1 states wide.
- wr_onehot[k] = wr_en && (wr_addr==k) for k=1..31.

Decomposition:
- Shared package: REG_ADDR_W=5, NUM_REGS=32, SRC_A=0, SRC_B=1, a writeback-entry struct {valid, addr, data}.
- Sub-module: wb_fifo, a DEPTH-entry FIFO with per-entry valid bits and an address-match invalidate port.
- One-hot output generated by the common 5-to-32 decoder, gated by wr_en.

Test Plan:
- Reset: hold reset=0 for 2 cycles with a_valid=1 and b_valid=1 → all wr_* =0, b_pending=0, b_ready=1 after release.
- Basic A: a_valid=1, a_addr=7, a_data=0xDEADBEEF at t → at t+1 wr_en=1, wr_addr=7, wr_onehot=0x00000080, wr_src=0.
- Starvation:
  - Stimulus: B enqueues addr 3, data 0x11 at t0; A requests continuously (addr 5).
  - Expected: A granted for 4 cycles. In cycle t0+5, a_ready=0 and B is granted; wr_addr=3, wr_src=1 appear in cycle t0+6.
- Full FIFO: 2 B enqueues while A is continuously busy → b_pending=2, b_ready=0; a third b_valid is held off until a pop.
- WAW squash:
  - Stimulus: B enqueues addr 9, data 0xAA; next cycle A writes addr 9, data 0xBB.
  - Expected: only a single write to r9 (0xBB); the B entry is popped silently and b_pending returns to 0.
- Register 0: A addr 0 and B addr 0 requests → wr_en stays 0, wr_onehot stays 0, b_pending stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and helpers for the writeback arbiter
// Contents: register-file geometry, source encodings, B-queue entry type, 5-to-32 decoder.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Widest writeback payload an entry can carry; the top-level DATA_W must not exceed it.
  localparam int WB_DATA_W  = 32;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] decode_5to32(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// rtl/regfile_wb_arbiter_wb_fifo.sv - B-result FIFO with per-entry valid bits and address invalidate
// Ports: clock/reset (sync, active-low); i_push/i_push_entry enqueue; i_pop dequeue;
//        i_inv_en/i_inv_addr clear valid on matching entries; o_head, o_empty, o_full, o_count.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  wb_entry_t             i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_inv_en,
  input  logic [REG_ADDR_W-1:0] i_inv_addr,
  output wb_entry_t             o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  wb_entry_t        w_push_entry;

  // An entry arriving in the same cycle as a matching newer write is stored already dead.
  always_comb begin
    w_push_entry = i_push_entry;
    if (i_inv_en && (i_push_entry.addr == i_inv_addr)) w_push_entry.valid = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_inv_en && r_mem[i].valid && (r_mem[i].addr == i_inv_addr)) r_mem[i].valid <= 1'b0;
      end
      // Slot being written is free (not full), so this overrides any invalidate above.
      if (i_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source arbiter for the register file write port
// Ports: clock/reset (sync, active-low); a_* pipeline writeback (high priority, unbuffered);
//        b_* mult/div results (queued); wr_* registered write port; b_pending queue occupancy.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [REG_ADDR_W-1:0]  a_addr,
  input  logic [DATA_W-1:0]      a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [REG_ADDR_W-1:0]  b_addr,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   b_ready,
  output logic                   wr_en,
  output logic [REG_ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [NUM_REGS-1:0]    wr_onehot,
  output logic                   wr_src,
  output logic [$clog2(DEPTH):0] b_pending
);

  localparam int              ST_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIMIT);

  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;
  logic                  r_wr_src;
  logic [ST_W-1:0]       r_starve;

  wb_entry_t w_head;
  wb_entry_t w_push_entry;
  logic      w_empty;
  logic      w_full;
  logic      w_head_live;
  logic      w_head_dead;
  logic      w_force_b;
  logic      w_a_grant;
  logic      w_b_grant;
  logic      w_pop;
  logic      w_push;
  logic      w_squash;

  assign w_head_live = !w_empty && w_head.valid;
  assign w_head_dead = !w_empty && !w_head.valid;
  assign w_force_b   = w_head_live && (r_starve == ST_MAX);

  assign a_ready   = !w_force_b;
  assign b_ready   = !w_full;
  assign w_a_grant = a_valid && !w_force_b;
  assign w_b_grant = w_head_live && (w_force_b || !a_valid);
  // A squashed head is dropped without using the write slot.
  assign w_pop     = w_b_grant || w_head_dead;
  // Writes to r0 are architecturally void, so they are never queued.
  assign w_push    = b_valid && b_ready && (b_addr != '0);
  assign w_squash  = w_a_grant && (a_addr != '0);

  assign w_push_entry = '{valid: 1'b1, addr: b_addr, data: WB_DATA_W'(b_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_entry(w_push_entry),
    .i_pop       (w_pop),
    .i_inv_en    (w_squash),
    .i_inv_addr  (a_addr),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (b_pending)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= SRC_A;
      r_starve  <= '0;
    end else begin
      r_wr_en <= w_squash || w_b_grant;
      if (w_squash) begin
        r_wr_addr <= a_addr;
        r_wr_data <= a_data;
        r_wr_src  <= SRC_A;
      end else if (w_b_grant) begin
        r_wr_addr <= w_head.addr;
        r_wr_data <= DATA_W'(w_head.data);
        r_wr_src  <= SRC_B;
      end
      if (w_b_grant || !w_head_live) r_starve <= '0;
      else if (r_starve != ST_MAX)   r_starve <= r_starve + 1'b1;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_src    = r_wr_src;
  assign wr_onehot = r_wr_en ? (decode_5to32(r_wr_addr) & ~NUM_REGS'(1)) : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int DATA_W       = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              a_valid = 1'b0;
  logic [4:0]        a_addr = '0;
  logic [DATA_W-1:0] a_data = '0;
  logic              a_ready;
  logic              b_valid = 1'b0;
  logic [4:0]        b_addr = '0;
  logic [DATA_W-1:0] b_data = '0;
  logic              b_ready;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       wr_onehot;
  logic              wr_src;
  logic [1:0]        b_pending;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_onehot(wr_onehot),
    .wr_src(wr_src), .b_pending(b_pending)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          live;
  } mentry_t;

  mentry_t     mq[$];
  int          m_starve;
  bit          e_en;
  int          e_addr;
  logic [31:0] e_data;
  bit          e_src;

  int          total = 0;
  int          bad = 0;
  bit          power_up = 1'b1;
  int          w9_count;
  logic [31:0] w9_data;
  logic        obs_a_ready;
  logic        obs_b_ready;
  logic [1:0]  obs_b_pending;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the reference model is a queue of pending B results.
  task automatic cycle(input bit rn, input bit av, input int aa, input logic [31:0] ad,
                       input bit bv, input int ba, input logic [31:0] bd);
    bit          head_live, head_dead, force_b, a_acc, b_gr, b_enq, squash;
    logic [31:0] exp_onehot;
    reset   = rn;
    a_valid = av;
    a_addr  = aa[4:0];
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba[4:0];
    b_data  = bd;
    #1;
    head_live     = (mq.size() > 0) && mq[0].live;
    head_dead     = (mq.size() > 0) && !mq[0].live;
    force_b       = head_live && (m_starve == STARVE_LIMIT);
    obs_a_ready   = a_ready;
    obs_b_ready   = b_ready;
    obs_b_pending = b_pending;
    if (!power_up) begin
      check("a_ready", a_ready, !force_b);
      check("b_ready", b_ready, mq.size() < DEPTH);
      check("b_pending", b_pending, mq.size());
    end
    @(posedge clock);
    if (!rn) begin
      mq.delete();
      m_starve = 0;
      e_en = 0; e_addr = 0; e_data = 0; e_src = 0;
    end else begin
      a_acc  = av && !force_b;
      b_gr   = head_live && (force_b || !av);
      b_enq  = bv && (mq.size() < DEPTH);
      squash = a_acc && (aa != 0);
      e_en   = 0;
      if (squash) begin
        e_en = 1; e_addr = aa; e_data = ad; e_src = 0;
      end else if (b_gr) begin
        e_en = 1; e_addr = mq[0].addr; e_data = mq[0].data; e_src = 1;
      end
      if (b_gr || !head_live) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
      if (b_gr || head_dead) void'(mq.pop_front());
      if (squash) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 0;
      if (b_enq && ba != 0) mq.push_back('{addr: ba, data: bd, live: !(squash && ba == aa)});
    end
    #1;
    power_up   = 1'b0;
    exp_onehot = e_en ? (32'h1 << e_addr) : 32'h0;
    check("wr_en", wr_en, e_en);
    check("wr_onehot", wr_onehot, exp_onehot);
    if (e_en || !rn) begin
      check("wr_addr", wr_addr, e_addr);
      check("wr_data", wr_data, e_data);
      check("wr_src", wr_src, e_src);
    end
    if (wr_en === 1'b1 && wr_addr === 5'd9) begin
      w9_count++;
      w9_data = wr_data;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held two cycles with both requesters active.
    cycle(0, 1, 4, 32'h1234, 1, 6, 32'h5678);
    cycle(0, 1, 4, 32'h1234, 1, 6, 32'h5678);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rst_b_ready", obs_b_ready, 1'b1);
    check("rst_b_pending", obs_b_pending, 2'd0);

    // Basic A write.
    cycle(1, 1, 7, 32'hDEADBEEF, 0, 0, 0);
    check("basicA_onehot", wr_onehot, 32'h0000_0080);
    check("basicA_data", wr_data, 32'hDEADBEEF);
    check("basicA_src", wr_src, 1'b0);
    idle(1);

    // Starvation: B queued at t0, A streams to r5; B forced through at t0+5.
    cycle(1, 1, 5, 32'h100, 1, 3, 32'h11);
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 1, 5, 32'h100 + k, 0, 0, 0);
      if (k == 4) check("starve_a_ready_t4", obs_a_ready, 1'b1);
    end
    check("starve_a_ready_t5", obs_a_ready, 1'b0);
    check("starve_wr_addr", wr_addr, 5'd3);
    check("starve_wr_src", wr_src, 1'b1);
    check("starve_wr_data", wr_data, 32'h11);
    idle(2);

    // Full FIFO while A is busy; third B request waits for a pop.
    cycle(1, 1, 5, 32'h200, 1, 10, 32'hA0);
    cycle(1, 1, 5, 32'h201, 1, 11, 32'hA1);
    for (int k = 0; k < 6; k++) begin
      cycle(1, 1, 5, 32'h202 + k, 1, 12, 32'hA2);
      if (k == 0) begin
        check("full_b_pending", obs_b_pending, 2'd2);
        check("full_b_ready", obs_b_ready, 1'b0);
      end
    end
    idle(6);

    // Write-after-write squash of a queued B result.
    w9_count = 0;
    cycle(1, 0, 0, 0, 1, 9, 32'hAA);
    cycle(1, 1, 9, 32'hBB, 0, 0, 0);
    idle(3);
    check("waw_count", w9_count, 1);
    check("waw_data", w9_data, 32'hBB);
    check("waw_pending", b_pending, 2'd0);

    // Register 0 from both sources.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 32'hF0 + k, 1, 0, 32'hE0 + k);
      check("r0_wr_en", wr_en, 1'b0);
      check("r0_onehot", wr_onehot, 32'h0);
      check("r0_pending", b_pending, 2'd0);
    end

    // Random traffic with a small address pool to provoke collisions, plus rare resets.
    for (int n = 0; n < 400; n++) begin
      int pa, pb;
      pa = $urandom_range(0, 6);
      pb = $urandom_range(0, 6);
      if (pa == 6) pa = 9;
      if (pb == 6) pb = 9;
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6, pa, $urandom,
            $urandom_range(0, 9) < 5, pb, $urandom);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
